isram_resp: RTL and testbench
=============================

Name: isram_resp

Overview:
- Responder end of the instruction SRAM port driven by the fetch stage.
- Holds a synchronous word-organised memory, accepts `en`/`wen`/`addr`/`wdata` requests and returns `rdata` one cycle later.
- After reset it runs a fill sweep that writes `FILL_WORD` into every location, then serves requests.
- Sits between the IF stage and the instruction store; used as the on-chip instruction RAM in simulation and FPGA builds.

Parameters:
- `AW`, 10: word-address width; depth = 2^AW words.
- `FILL_WORD`, 32'h0000_0000: value written to every word during the post-reset sweep.
- `BASE`, 32'h0000_0000: physical byte address of word 0; must be aligned to 4*2^AW.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `inst_sram_en`  in  1: request valid this cycle.
- `inst_sram_wen`  in  4: byte write enables; bit i writes byte lane i (`wdata[8i+7:8i]`).
- `inst_sram_addr`  in  32: physical byte address.
- `inst_sram_wdata`  in  32: write data.
- `inst_sram_rdata`  out  32: read data, registered.
- `busy`  out  1: fill sweep in progress; requests ignored.
- `addr_err`  out  1: one-cycle pulse, one cycle after an out-of-range accepted request.

Behaviour:
- **Reset** (`rst`=1 at an edge): `rdata`<=0, `addr_err`<=0, sweep counter<=0, state<=FILL, `busy`=1 from the next cycle. Memory contents are not cleared by reset itself.
- **State FILL:**
  - Each cycle writes `FILL_WORD` to `mem[cnt]` and increments `cnt`.
  - When `cnt` reaches 2^AW-1, it writes that word and moves to RUN on the same edge.
  - Takes exactly 2^AW cycles; `busy`=1 throughout.
  - `en`/`wen` are ignored; `rdata` holds 0; `addr_err` stays 0.
- **State RUN:** `busy`=0; stays in RUN until `rst`.
- **Reset mid-FILL:** sweep restarts from word 0 with the full 2^AW-cycle duration.
- **Address decode:**
  - `off` = `addr` - `BASE`.
  - In range iff `off[31:AW+2]`==0.
  - Word index = `off[AW+1:2]`; `addr[1:0]` is ignored (alignment checking belongs to the requester).
- **Read (RUN, en=1, in range):** `rdata`<=`mem[idx]` at the edge; visible the following cycle (latency 1).
- **Write (RUN, en=1, wen!=0, in range):**
  - Only the enabled byte lanes of `mem[idx]` are updated at the edge.
  - `rdata` for the same request returns the OLD word (read-first).
- **Consecutive requests:** a write followed by a read of the same word returns the new data.
- **en=0:** `rdata` holds its previous value indefinitely. The fetch stage relies on this when stalled.
- **Out of range (RUN, en=1):** no memory update; `rdata`<=0; `addr_err`=1 for exactly the next cycle.
- **Simultaneous events:** `rst` wins over any request. A request in the cycle `busy` falls is not served; the first serviceable request is in the first cycle with `busy`=0.
- **Widths:** `off` uses 32-bit modular subtraction, so addresses below `BASE` wrap and are reported out of range.

Optional Feature:
- Macro: `ISRAM_STATS_EN`.
- **Defined:**
  - Adds outputs `rd_cnt[31:0]` and `wr_cnt[31:0]`, both reset to 0 by `rst`.
  - `rd_cnt` increments on every accepted in-range request with `wen`==0.
  - `wr_cnt` increments on every accepted in-range request with `wen`!=0.
  - Both wrap modulo 2^32; out-of-range and FILL-state requests are not counted.
- **Undefined:** neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- **Fill sweep:** AW=4, FILL_WORD=32'h0000_0000; assert `rst` 1 cycle -> `busy`=1 for exactly 16 cycles; then read all 16 words -> each `rdata`=0 one cycle after its request.
- **Byte-lane write:**
  - Write addr=0x8, wen=4'hF, wdata=32'hDEAD_BEEF, then wen=4'b0101, wdata=32'h1122_3344.
  - Read 0x8 -> `rdata`=32'hDE22_BE44.
  - `rdata` during the second write cycle's response = 32'hDEAD_BEEF (read-first).
- **Hold on idle:** read 0x8, then en=0 for 5 cycles -> `rdata` stays 32'hDE22_BE44; addr changes while en=0 have no effect.
- **Out of range:** AW=4, BASE=0; read addr=0x40 -> `rdata`=0, `addr_err`=1 for one cycle. Write to 0x40 then read 0x0 -> `mem[0]` unchanged.
- **Reset mid-fill:** AW=4; assert `rst` at sweep cycle 7 -> `busy` remains high for 16 further cycles. Pre-filled words reread as `FILL_WORD`; a request issued while `busy` has no effect.
- **Stats (ISRAM_STATS_EN):** after fill, 3 reads, 2 writes, 1 out-of-range read -> `rd_cnt`=3, `wr_cnt`=2. After `rst` -> both 0.

Source files
------------

// File: rtl/isram_resp_if.sv
// isram_resp_if: instruction-SRAM request/response bundle between the fetch
// stage (master) and the instruction RAM responder (slave).
//   inst_sram_en    : request valid this cycle
//   inst_sram_wen   : byte write enables, bit i -> wdata[8i+7:8i]
//   inst_sram_addr  : physical byte address
//   inst_sram_wdata : write data
//   inst_sram_rdata : registered read data, one cycle after the request
interface isram_resp_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  modport master (
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    input  inst_sram_rdata
  );

  modport slave (
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    output inst_sram_rdata
  );
endinterface

// File: rtl/isram_resp.sv
// isram_resp: on-chip instruction RAM responder for the IF stage.
// After reset a sweep writes FILL_WORD into every word (busy=1 for exactly
// 2^AW cycles), then byte-masked read-first requests are served with a
// one-cycle registered read latency.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   bus      : isram_resp_if.slave (en/wen/addr/wdata in, rdata out)
//   busy     : fill sweep in progress, requests ignored
//   addr_err : one-cycle pulse after an accepted out-of-range request
// Optional: define ISRAM_STATS_EN to add rd_cnt/wr_cnt request counters.
module isram_resp #(
  parameter int          AW        = 10,
  parameter logic [31:0] FILL_WORD = 32'h0000_0000,
  parameter logic [31:0] BASE      = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  isram_resp_if.slave     bus,
  output logic            busy,
  output logic            addr_err
`ifdef ISRAM_STATS_EN
  ,
  output logic [31:0]     rd_cnt,
  output logic [31:0]     wr_cnt
`endif
);

  localparam int          DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST = '1;

  typedef enum logic {S_FILL = 1'b0, S_RUN = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_cnt;
  logic [31:0]     r_rdata;
  logic            r_addr_err;
  logic [31:0]     r_mem [DEPTH];

  logic [29:0]     w_woff;
  logic            w_in_range;
  logic [AW-1:0]   w_idx;
  logic            w_acc;
  logic            w_rd_ok;
  logic            w_wr;
  logic            w_busy;

  // BASE is aligned to the RAM size, so its low two bits are zero and the
  // word-granular subtraction equals the byte offset with addr[1:0] dropped.
  assign w_woff     = bus.inst_sram_addr[31:2] - BASE[31:2];
  assign w_in_range = (w_woff[29:AW] == '0);
  assign w_idx      = w_woff[AW-1:0];
  assign w_acc      = (r_state == S_RUN) && bus.inst_sram_en;
  assign w_rd_ok    = w_acc && w_in_range;
  assign w_wr       = w_rd_ok && (bus.inst_sram_wen != 4'b0000);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FILL;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    case (r_state)
      S_FILL: begin
        w_busy = 1'b1;
        if (r_cnt == LAST) w_state_nxt = S_RUN;
      end
      S_RUN:   w_busy = 1'b0;
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                   r_cnt <= '0;
    else if (r_state == S_FILL) r_cnt <= r_cnt + 1'b1;
  end

  // Storage has no reset; the sweep initialises it. Reset suppresses writes
  // so a reset edge never collides with a request or a sweep step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_FILL) begin
        r_mem[r_cnt] <= FILL_WORD;
      end else if (w_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.inst_sram_wen[b]) r_mem[w_idx][8*b +: 8] <= bus.inst_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read-first response: rdata captures the word before this edge's write.
  // With no accepted request rdata holds, which stalled fetch relies on.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata    <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= w_acc && !w_in_range;
      if (w_acc) r_rdata <= w_in_range ? r_mem[w_idx] : 32'h0000_0000;
    end
  end

`ifdef ISRAM_STATS_EN
  logic [31:0] r_rd_cnt;
  logic [31:0] r_wr_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (w_rd_ok) begin
      if (w_wr) r_wr_cnt <= r_wr_cnt + 32'd1;
      else      r_rd_cnt <= r_rd_cnt + 32'd1;
    end
  end

  assign rd_cnt = r_rd_cnt;
  assign wr_cnt = r_wr_cnt;
`endif

  assign bus.inst_sram_rdata = r_rdata;
  assign busy                = w_busy;
  assign addr_err            = r_addr_err;

endmodule

// File: tb/tb_isram_resp.sv
// tb_isram_resp: bench for isram_resp (AW=4). A word-array reference model
// tracks memory, read data, busy and addr_err from the behavioural rules;
// a negedge process compares the DUT against it every cycle, and directed
// sequences pin the model with literal expectations.
module tb_isram_resp;
  localparam int          AW    = 4;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] FILLW = 32'hA5A5_5A5A;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic clk;
  logic rst;
  logic busy;
  logic addr_err;
`ifdef ISRAM_STATS_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
`endif

  isram_resp_if bus ();

  isram_resp #(.AW(AW), .FILL_WORD(FILLW), .BASE(BASE)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .addr_err (addr_err)
`ifdef ISRAM_STATS_EN
    ,
    .rd_cnt   (rd_cnt),
    .wr_cnt   (wr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rdata;
  logic        m_err;
  logic        m_busy;
  logic        m_valid = 1'b0;
  int          m_fill_left;
  logic [31:0] m_rd;
  logic [31:0] m_wr;
  logic [31:0] t_off;

  assign t_off = bus.inst_sram_addr - BASE;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      // The sweep leaves every word at FILLW before any request is served.
      m_valid     <= 1'b1;
      m_rdata     <= 32'h0;
      m_err       <= 1'b0;
      m_busy      <= 1'b1;
      m_fill_left <= DEPTH;
      m_rd        <= 32'h0;
      m_wr        <= 32'h0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= FILLW;
    end else if (m_fill_left > 0) begin
      m_fill_left <= m_fill_left - 1;
      m_busy      <= (m_fill_left > 1);
      m_err       <= 1'b0;
    end else begin
      m_busy <= 1'b0;
      m_err  <= 1'b0;
      if (bus.inst_sram_en) begin
        if (t_off < 32'(4 * DEPTH)) begin
          m_rdata <= m_mem[t_off / 4];
          if (bus.inst_sram_wen != 4'h0) begin
            m_mem[t_off / 4] <= merge(m_mem[t_off / 4], bus.inst_sram_wdata, bus.inst_sram_wen);
            m_wr <= m_wr + 32'd1;
          end else begin
            m_rd <= m_rd + 32'd1;
          end
        end else begin
          m_rdata <= 32'h0;
          m_err   <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", {31'b0, busy}, {31'b0, m_busy});
      chk("addr_err", {31'b0, addr_err}, {31'b0, m_err});
      chk("rdata", bus.inst_sram_rdata, m_rdata);
`ifdef ISRAM_STATS_EN
      chk("rd_cnt", rd_cnt, m_rd);
      chk("wr_cnt", wr_cnt, m_wr);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic r, input logic e, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d);
    rst                 = r;
    bus.inst_sram_en    = e;
    bus.inst_sram_wen   = w;
    bus.inst_sram_addr  = a;
    bus.inst_sram_wdata = d;
  endtask

  task automatic drive(input logic r, input logic e, input logic [3:0] w,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    set_in(r, e, w, a, d);
  endtask

  task automatic wait_fill(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  int nb;

  initial begin
    set_in(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);

    // Fill sweep after reset: busy for exactly DEPTH cycles, all words FILLW.
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    wait_fill(nb);
    chk("fill_busy_cycles", 32'(nb), 32'd16);
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) drive(1'b0, 1'b1, 4'h0, BASE + 32'(4 * i), 32'h0);
      else           drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      if (i > 0) chk("fill_word", bus.inst_sram_rdata, 32'hA5A5_5A5A);
    end

    // Byte-lane write, read-first response, then readback of merged word.
    drive(1'b0, 1'b1, 4'hF,    BASE + 32'h8, 32'hDEAD_BEEF);
    drive(1'b0, 1'b1, 4'b0101, BASE + 32'h8, 32'h1122_3344);
    drive(1'b0, 1'b1, 4'h0,    BASE + 32'h8, 32'h0);
    chk("read_first", bus.inst_sram_rdata, 32'hDEAD_BEEF);
    drive(1'b0, 1'b0, 4'h0, BASE + 32'h8, 32'h0);
    chk("byte_lane_merge", bus.inst_sram_rdata, 32'hDE22_BE44);

    // Hold on idle while addr/wen wander with en low.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 4'hF, BASE + 32'(4 * i), $urandom);
      chk("hold_idle", bus.inst_sram_rdata, 32'hDE22_BE44);
    end

    // Out-of-range read, pulse width, write that must not land, below-BASE wrap.
    drive(1'b0, 1'b1, 4'h0, BASE + 32'h40, 32'h0);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("oor_rdata", bus.inst_sram_rdata, 32'h0);
    chk("oor_err", {31'b0, addr_err}, 32'd1);
    drive(1'b0, 1'b1, 4'hF, BASE + 32'h40, 32'h1234_5678);
    chk("oor_err_pulse", {31'b0, addr_err}, 32'd0);
    drive(1'b0, 1'b1, 4'h0, BASE, 32'h0);
    drive(1'b0, 1'b1, 4'h0, BASE - 32'h4, 32'h0);
    chk("oor_no_write", bus.inst_sram_rdata, 32'hA5A5_5A5A);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("below_base_err", {31'b0, addr_err}, 32'd1);

    // Reset partway through the sweep; requests during busy are ignored.
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 4'hF, BASE + 32'h8, 32'h0BAD_0000);
    drive(1'b1, 1'b1, 4'hF, BASE + 32'h8, 32'h0BAD_0001);
    drive(1'b0, 1'b1, 4'hF, BASE + 32'hC, 32'h0BAD_0002);
    wait_fill(nb);
    set_in(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("midfill_busy_cycles", 32'(nb), 32'd16);

`ifdef ISRAM_STATS_EN
    drive(1'b0, 1'b1, 4'h0, BASE + 32'h4, 32'h0);
    drive(1'b0, 1'b1, 4'h3, BASE + 32'h10, 32'hCAFE_F00D);
    drive(1'b0, 1'b1, 4'h0, BASE + 32'h14, 32'h0);
    drive(1'b0, 1'b1, 4'h0, BASE + 32'h80, 32'h0);
    drive(1'b0, 1'b1, 4'h8, BASE + 32'h18, 32'h7700_0000);
    drive(1'b0, 1'b1, 4'h0, BASE + 32'h1C, 32'h0);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("stats_rd", rd_cnt, 32'd3);
    chk("stats_wr", wr_cnt, 32'd2);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("stats_rd_rst", rd_cnt, 32'd0);
    chk("stats_wr_rst", wr_cnt, 32'd0);
    wait_fill(nb);
`endif

    drive(1'b0, 1'b1, 4'h0, BASE + 32'h8, 32'h0);
    drive(1'b0, 1'b1, 4'h0, BASE + 32'hC, 32'h0);
    chk("midfill_word2", bus.inst_sram_rdata, 32'hA5A5_5A5A);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("midfill_word3", bus.inst_sram_rdata, 32'hA5A5_5A5A);

    // Randomised traffic with occasional resets, checked by the model.
    for (int rnd = 0; rnd < 3; rnd++) begin
      drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
      for (int c = 0; c < 400; c++) begin
        logic        r;
        logic        e;
        logic [3:0]  w;
        logic [31:0] a;
        int          sel;
        r   = ($urandom_range(0, 299) == 0);
        e   = ($urandom_range(0, 9) < 7);
        w   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        sel = $urandom_range(0, 9);
        if (sel < 7)       a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
        else if (sel == 7) a = $urandom;
        else if (sel == 8) a = BASE - 32'(4 * $urandom_range(1, 4));
        else               a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
        drive(r, e, w, a, $urandom);
      end
    end

    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
